// File: rtl/frac_clock_divider.sv
// Fractional clock divider: divides Clk by W + D/100 using a base-100 dither accumulator.
// Output periods are W or W+1 input cycles; ratio updates take effect only at period boundaries.
module frac_clock_divider #(
   parameter int FRAC_BASE = 100,
   parameter int MIN_WHOLE = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        En,
   input  logic [31:0] Div_In,
   input  logic        Load,
   output logic        Load_Ack,
   output logic        Clk_Out,
   output logic        Period_Tick,
   output logic        Err
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t      state_q, state_d;
   logic        en_p0;
   logic [24:0] wa_q, wa_d;
   logic [6:0]  da_q, da_d;
   logic [31:0] pend_q, pend_d;
   logic        pend_vld_q, pend_vld_d;
   logic [6:0]  acc_q, acc_d, acc_base;
   logic [25:0] per_q, per_d;
   logic [25:0] k_q, k_d;
   logic        ack_q, err_q, err_d;
   logic        tick, boundary, apply, start;
   logic [31:0] ratio_sel;
   logic [7:0]  sum;

   function automatic logic [24:0] clamp_whole(input logic [24:0] w);
      return (w < 25'(MIN_WHOLE)) ? 25'(MIN_WHOLE) : w;
   endfunction

   function automatic logic [6:0] clamp_frac(input logic [6:0] d);
      return (d >= 7'(FRAC_BASE)) ? 7'(FRAC_BASE - 1) : d;
   endfunction

   assign tick        = (state_q == RUN) && (k_q == per_q - 26'd1);
   assign Period_Tick = tick;
   // Odd periods give the extra cycle to the high phase.
   assign Clk_Out     = (state_q == RUN) && (k_q < per_q - (per_q >> 1));
   assign Load_Ack    = ack_q;
   assign Err         = err_q;

   always_comb begin
      boundary   = (state_q == IDLE) || tick;
      apply      = boundary && (pend_vld_q || Load);
      ratio_sel  = Load ? Div_In : pend_q;
      wa_d       = wa_q;
      da_d       = da_q;
      err_d      = err_q;
      acc_base   = acc_q;
      pend_d     = pend_q;
      pend_vld_d = pend_vld_q;
      if (apply) begin
         wa_d       = clamp_whole(ratio_sel[31:7]);
         da_d       = clamp_frac(ratio_sel[6:0]);
         err_d      = (wa_d != ratio_sel[31:7]) || (da_d != ratio_sel[6:0]);
         acc_base   = '0;
         pend_vld_d = 1'b0;
      end else if (Load) begin
         pend_d     = Div_In;
         pend_vld_d = 1'b1;
      end

      sum     = {1'b0, acc_base} + {1'b0, da_d};
      state_d = state_q;
      k_d     = k_q;
      per_d   = per_q;
      acc_d   = acc_base;
      start   = 1'b0;
      case (state_q)
         IDLE: begin
            acc_d = '0;
            k_d   = '0;
            if (en_p0 && En) begin
               state_d = RUN;
               start   = 1'b1;
            end
         end
         RUN: begin
            if (!En) begin
               state_d = IDLE;
               acc_d   = '0;
               k_d     = '0;
            end else if (tick) begin
               start = 1'b1;
            end else begin
               k_d = k_q + 26'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Period start: the accumulator overflow decides between W and W+1.
      if (start) begin
         k_d = '0;
         if (sum >= 8'(FRAC_BASE)) begin
            per_d = {1'b0, wa_d} + 26'd1;
            acc_d = 7'(sum - 8'(FRAC_BASE));
         end else begin
            per_d = {1'b0, wa_d};
            acc_d = sum[6:0];
         end
      end
   end

   // Control and ratio state.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= IDLE;
         en_p0      <= 1'b0;
         wa_q       <= 25'(MIN_WHOLE);
         da_q       <= '0;
         pend_vld_q <= 1'b0;
         acc_q      <= '0;
         per_q      <= 26'(MIN_WHOLE);
         k_q        <= '0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         en_p0      <= En;
         wa_q       <= wa_d;
         da_q       <= da_d;
         pend_vld_q <= pend_vld_d;
         acc_q      <= acc_d;
         per_q      <= per_d;
         k_q        <= k_d;
         ack_q      <= apply;
         err_q      <= err_d;
      end
   end

   // Pending ratio payload; qualified by pend_vld_q.
   always_ff @(posedge Clk) begin
      pend_q <= pend_d;
   end

endmodule

// File: doc/frac_clock_divider.md
# frac_clock_divider

Consumer of the packed divide-ratio words that the controller produces on C_N1/C_N2. It divides the ring-oscillator clock by a fixed-point ratio of whole.hundredths: field [31:7] is the integer part W, field [6:0] is the hundredths part D. It generates output periods of W or W+1 input cycles, dithered by a base-100 accumulator, so the long-run average period is W + D/100 cycles. One instance sits after the controller on each divided path.

## Interface

Parameters:
- FRAC_BASE, 100, modulus of the hundredths accumulator.
- MIN_WHOLE, 2, smallest legal integer part W.

Ports:
- Clk, input, 1, ring-oscillator clock; all logic is on the rising edge.
- Reset, input, 1, asynchronous, active-high; clears all state.
- En, input, 1, run enable.
- Div_In, input, 32, packed ratio: [31:7] = W, [6:0] = D.
- Load, input, 1, single-cycle strobe that stages Div_In.
- Load_Ack, output, 1, one-cycle pulse when a staged ratio becomes active.
- Clk_Out, output, 1, divided clock.
- Period_Tick, output, 1, high in the last input cycle of each output period.
- Err, output, 1, set when an applied ratio was clamped.

## Operation

- Registers:
  - active ratio (Wa, Da), reset value 2.00
  - pending ratio plus pending flag
  - accumulator acc, 0..FRAC_BASE-1
  - period length P
  - cycle counter k
  - state IDLE or RUN
- Staging: Load=1 captures Div_In into the pending register and sets the pending flag. A second Load before it is applied overwrites the pending value.
- Apply: happens at a boundary, meaning the Period_Tick cycle or any cycle in IDLE.
  - If pending is set (or Load=1 in that same cycle, in which case Div_In is used directly), the pending ratio moves to active.
  - The pending flag clears, acc clears to 0, and Load_Ack pulses in the next cycle.
- Clamping on apply:
  - W < MIN_WHOLE becomes MIN_WHOLE.
  - D >= FRAC_BASE becomes FRAC_BASE-1.
  - Err=1 if either clamp occurred, else Err=0. Err holds until the next apply.
- Period start:
  - s = acc + Da.
  - If s >= FRAC_BASE: P = Wa+1 and acc = s - FRAC_BASE.
  - Else: P = Wa and acc = s.
  - k starts at 0. The first period after an apply is always Wa.
- Within a period, for k = 0..P-1:
  - Clk_Out = 1 for k < P - floor(P/2), else 0. For odd P the extra cycle is high.
  - Period_Tick = 1 at k = P-1.
- State machine:
  - IDLE → RUN when En=1. The first period starts in the following cycle.
  - RUN → RUN at every Period_Tick while En=1.
  - RUN → IDLE immediately when En=0, including mid-period. In IDLE, Clk_Out, Period_Tick and k are 0 and acc clears.
- Arithmetic widths: W is 25 bits, so P is 26 bits to hold Wa+1 without overflow. acc plus D fits in 8 bits.

## Timing

- Reset (asynchronous):
  - Clk_Out, Period_Tick, Load_Ack and Err go to 0 immediately.
  - State IDLE, active ratio 2.00, pending cleared, acc = 0.
- Latency:
  - En rise to first Clk_Out high: 2 cycles (the enable is registered, then the period starts).
  - Load to Load_Ack: up to the end of the current period, plus 1 cycle.
  - In IDLE: Load in cycle n gives Load_Ack in cycle n+1.
- Simultaneous events:
  - Load together with Period_Tick: the new ratio governs the very next period.
  - Load together with En falling: the value is staged and applied in IDLE.
- Reset during a pending Load: the pending value is discarded and no Load_Ack is issued.
- Counter wrap: k never exceeds P-1. P is recomputed only at period start, so Div_In changes without Load have no effect.

## Test plan

- Ratio 4.00 with En held at 1:
  - Clk_Out repeats 1,1,0,0.
  - Period_Tick every 4th cycle.
  - Load_Ack exactly once after the initial load.
- Ratio 2.50:
  - Period lengths 2,3,2,3,…
  - Exactly 80 Period_Ticks in 200 cycles after the first period start.
- Ratio 3.33:
  - 100 consecutive periods span exactly 333 input cycles.
  - Periods of 3 show Clk_Out 1,1,0; periods of 4 show 1,1,0,0.
- Running at 4.00, Load 5.00 at k=1:
  - The current period still lasts 4.
  - Load_Ack coincides with k=0 of the next period, which lasts 5.
  - Load 6.00 then 7.00 before the boundary: only 7.00 is applied, with a single Load_Ack.
- Div_In with W=1, D=0: applied as 2.00 and Err=1. Div_In with W=3, D=120: applied as 3.99 and Err=1. A following load of 3.00 clears Err.
- Asynchronous Reset asserted mid-period at ratio 5.00:
  - All outputs go to 0 before the next edge.
  - After release with En=1, the output runs at 2.00.
  - Dropping En mid-period forces Clk_Out=0 on the next cycle.
